row_replay: RTL

ROW_REPLAY -- requirements
Module: row_replay

---
 rtl/layernorm_pkg.sv | 15 +
 rtl/row_replay_mem.sv | 30 +++
 rtl/row_replay.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/layernorm_pkg.sv
// layernorm_pkg: shared types for the layernorm row path.
// Holds the binary32 element type and the replay FSM states.
package layernorm_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_STAT = 2'd1,
    REPLAY    = 2'd2
  } rd_state_t;

  localparam int STAT_DEPTH = 2;

endpackage

// File: rtl/row_replay_mem.sv
// row_replay_mem: simple dual-port row buffer RAM.
// One write port, one read port with a 1-cycle registered read.
module row_replay_mem
  import layernorm_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fp32_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output fp32_t         rdata
);

  fp32_t mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/row_replay.sv
// row_replay: ping-pong row buffer replaying each row with its statistic.
// Optional macro ROW_REPLAY_LEN_CHECK_EN drops elements beyond N and flags err.
module row_replay
  import layernorm_pkg::*;
#(
  parameter int N     = 1024,
  parameter int BANKS = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  fp32_t a,
  input  logic  avld,
  input  logic  alst,
  output logic  ardy,
  input  fp32_t s,
  input  logic  svld,
  output fp32_t y,
  output fp32_t ys,
  output logic  yvld,
  output logic  ylst,
  input  logic  yrdy,
  output logic  err
);

  localparam int AW    = $clog2(N);
  localparam int CW    = AW + 1;
  localparam int DEPTH = BANKS * N;

  typedef logic [CW-1:0] cnt_t;

  logic      wb;
  cnt_t      wcnt;
  logic [1:0] closed;
  cnt_t      len [2];
  logic      acc;
  logic      room;
  logic      ovf;
  logic      we;
  cnt_t      wlen;

  fp32_t     sf [2];
  logic      sw;
  logic      sr;
  logic [1:0] sc;
  logic      push;
  logic      pop;
  logic      sovf;

  rd_state_t st;
  logic      rb;
  cnt_t      rcnt;
  logic      rdone;
  logic      pv;
  logic      pl;
  fp32_t     sk_d;
  logic      sk_l;
  logic      sk_v;
  logic      take;
  logic [1:0] occ;
  logic      issue;
  logic      rlast;
  logic      rel;
  fp32_t     rdata;

  assign ardy = !closed[wb];
  assign acc  = avld && ardy;

`ifdef ROW_REPLAY_LEN_CHECK_EN
  assign room = wcnt < cnt_t'(N);
  assign ovf  = acc && !room;
  assign wlen = room ? wcnt + cnt_t'(1) : cnt_t'(N);
`else
  assign room = 1'b1;
  assign ovf  = 1'b0;
  assign wlen = wcnt + cnt_t'(1);
`endif

  assign we = acc && room;

  assign push = svld && (sc != 2'(STAT_DEPTH));
  assign sovf = svld && (sc == 2'(STAT_DEPTH));
  assign pop  = (st == WAIT_STAT) && (sc != 2'd0);

  assign take  = yvld && yrdy;
  assign occ   = {1'b0, yvld} + {1'b0, sk_v} + {1'b0, pv};
  assign rlast = rcnt == len[rb] - cnt_t'(1);
  assign issue = (st == REPLAY) && !rdone &&
                 (occ <= {1'b0, take} + 2'd1);
  assign rel   = (st == REPLAY) && take && ylst;

  row_replay_mem #(
    .DEPTH (DEPTH),
    .AW    (AW + 1)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr ({wb, wcnt[AW-1:0]}),
    .wdata (a),
    .re    (issue),
    .raddr ({rb, rcnt[AW-1:0]}),
    .rdata (rdata)
  );

  // write side: fill bank wb, close it on alst, reopen after replay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb     <= 1'b0;
      wcnt   <= '0;
      closed <= '0;
      for (int i = 0; i < 2; i++) len[i] <= '0;
    end else begin
      if (rel) closed[rb] <= 1'b0;
      if (acc) begin
        if (alst) begin
          closed[wb] <= 1'b1;
          len[wb]    <= wlen;
          wb         <= ~wb;
          wcnt       <= '0;
        end else if (room) begin
          wcnt <= wcnt + cnt_t'(1);
        end
      end
    end
  end

  // statistic FIFO, two entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw <= 1'b0;
      sr <= 1'b0;
      sc <= 2'd0;
      for (int i = 0; i < 2; i++) sf[i] <= '0;
    end else begin
      if (push) begin
        sf[sw] <= s;
        sw     <= ~sw;
      end
      if (pop) sr <= ~sr;
      sc <= sc + {1'b0, push} - {1'b0, pop};
    end
  end

  // sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err | sovf | ovf;
  end

  // read FSM, read issue and output/skid registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= IDLE;
      rb    <= 1'b0;
      rcnt  <= '0;
      rdone <= 1'b0;
      ys    <= '0;
      pv    <= 1'b0;
      pl    <= 1'b0;
      y     <= '0;
      ylst  <= 1'b0;
      yvld  <= 1'b0;
      sk_d  <= '0;
      sk_l  <= 1'b0;
      sk_v  <= 1'b0;
    end else begin
      pv <= issue;
      pl <= issue && rlast;
      if (issue) begin
        rcnt <= rcnt + cnt_t'(1);
        if (rlast) rdone <= 1'b1;
      end
      if (!yvld || take) begin
        if (sk_v) begin
          y    <= sk_d;
          ylst <= sk_l;
          yvld <= 1'b1;
          sk_v <= pv;
          sk_d <= rdata;
          sk_l <= pl;
        end else if (pv) begin
          y    <= rdata;
          ylst <= pl;
          yvld <= 1'b1;
        end else begin
          yvld <= 1'b0;
          ylst <= 1'b0;
        end
      end else if (pv) begin
        sk_v <= 1'b1;
        sk_d <= rdata;
        sk_l <= pl;
      end
      unique case (st)
        IDLE: begin
          if (closed[rb]) st <= WAIT_STAT;
        end
        WAIT_STAT: begin
          if (sc != 2'd0) begin
            ys    <= sf[sr];
            st    <= REPLAY;
            rcnt  <= '0;
            rdone <= 1'b0;
          end
        end
        REPLAY: begin
          if (rel) begin
            st <= IDLE;
            rb <= ~rb;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
